// File: rtl/gpio_pkg.sv
// Shared constants and FSM encoding for the serial LED GPIO block.
package gpio_pkg;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_LED_W   = 16;
  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_INVERT  = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    LATCH = 3'd3,
    DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/gpio_serial_out_led_clk_div.sv
// Bit-period divider: counts 2*CLK_DIV cycles per bit, flags the high half
// and strobes at the end of the low half and at the end of the bit.
module led_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic clk_hi,
  output logic half_end,
  output logic bit_end
);
  localparam int CW = $clog2(2 * CLK_DIV) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign clk_hi   = (cnt_q >= CW'(CLK_DIV));
  assign half_end = en && (cnt_q == CW'(CLK_DIV - 1));
  assign bit_end  = en && (cnt_q == CW'(2 * CLK_DIV - 1));

  always_comb begin
    cnt_d = '0;
    if (en && !bit_end) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/gpio_serial_out.sv
// GPIO register with byte-enable writes and a serial LED shifter.
// Optional GPIO_AUTO_SHIFT_EN: LED-field changes on write trigger a transfer.
module gpio_serial_out
  import gpio_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LED_W   = DEF_LED_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int INVERT  = DEF_INVERT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic [DATA_W-1:0] gpio_q,
  output logic              busy,
  output logic              done,
  output logic              led_clk,
  output logic              led_sout,
  output logic              led_clrn,
  output logic              led_pen
);
  localparam int NB = DATA_W / 8;
  localparam int BW = $clog2(LED_W) + 1;
  localparam logic [LED_W-1:0] INV_MASK = (INVERT != 0) ? {LED_W{1'b1}} : {LED_W{1'b0}};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] gpio_d;
  logic [LED_W-1:0]  sr_q, sr_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              pending_q, pending_d;
  logic              led_clrn_q;
  logic              req;
  logic              div_en, clk_hi, half_end, bit_end;

  always_comb begin
    gpio_d = gpio_q;
    if (wr_en)
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) gpio_d[8*i +: 8] = wr_data[8*i +: 8];
  end

`ifdef GPIO_AUTO_SHIFT_EN
  assign req = start || (wr_en && (gpio_d[LED_W-1:0] != gpio_q[LED_W-1:0]));
`else
  assign req = start;
`endif

  assign div_en = (state_q == SHIFT) || (state_q == LATCH);

  led_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (div_en),
    .clk_hi   (clk_hi),
    .half_end (half_end),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: if (req) state_d = LOAD;
      LOAD: begin
        sr_d      = gpio_q[LED_W-1:0] ^ INV_MASK;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: if (bit_end) begin
        sr_d      = sr_q >> 1;
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BW'(LED_W - 1)) state_d = LATCH;
      end
      LATCH: if (half_end) state_d = DONE;
      DONE: begin
        // A request arriving in DONE itself is folded into the relaunch.
        state_d   = (pending_q || req) ? LOAD : IDLE;
        pending_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (req && state_q != IDLE && state_q != DONE) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gpio_q     <= '0;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      pending_q  <= 1'b0;
      led_clrn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gpio_q     <= gpio_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      pending_q  <= pending_d;
      led_clrn_q <= 1'b1;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign led_pen  = (state_q == LATCH);
  assign led_clk  = (state_q == SHIFT) && clk_hi;
  assign led_sout = (state_q == SHIFT) && sr_q[0];
  assign led_clrn = led_clrn_q;
endmodule

// File: tb/tb_gpio_serial_out.sv
// Randomized bench for gpio_serial_out against a frame-level reference model.
module tb_gpio_serial_out;
  localparam int DATA_W  = 32;
  localparam int LED_W   = 16;
  localparam int CLK_DIV = 2;
  localparam int INVERT  = 1;
  localparam int XFER    = 1 + 2*CLK_DIV*LED_W + CLK_DIV + 1;

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0, wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [3:0]        wr_be = '0;
  logic [DATA_W-1:0] gpio_q;
  logic busy, done, led_clk, led_sout, led_clrn, led_pen;

  gpio_serial_out #(.DATA_W(DATA_W), .LED_W(LED_W), .CLK_DIV(CLK_DIV), .INVERT(INVERT)) dut (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_data(wr_data), .wr_be(wr_be),
    .gpio_q(gpio_q), .busy(busy), .done(done), .led_clk(led_clk), .led_sout(led_sout),
    .led_clrn(led_clrn), .led_pen(led_pen));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [31:0] mdl = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] apply_wr(input logic [31:0] cur, input logic [31:0] d,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [15:0] frame_of(input logic [31:0] g);
    return g[15:0] ^ ((INVERT != 0) ? 16'hFFFF : 16'h0000);
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) chk({tag, " idle timeout"}, 1, 0);
  endtask

  task automatic wr(input string tag, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    wr_en = 1'b1; wr_data = d; wr_be = be;
    mdl = apply_wr(mdl, d, be);
    @(negedge clk);
    wr_en = 1'b0;
    chk({tag, " gpio_q"}, gpio_q, mdl);
`ifdef GPIO_AUTO_SHIFT_EN
    wait_idle(tag);
`endif
  endtask

  // extra: number of additional starts issued while busy; wr_cyc<0 writes with start
  task automatic xfer(input string tag, input int extra, input int wr_cyc, input logic [31:0] wd);
    logic [15:0] f0, fw;
    logic bits[$];
    int dones[$];
    int k, pen, nx, bad_idle, unstable;
    logic pclk, hold;
    logic auto_trig;
    @(negedge clk);
    start = 1'b1;
    if (wr_cyc < 0) begin
      wr_en = 1'b1; wr_data = wd; wr_be = 4'hF;
      mdl = apply_wr(mdl, wd, 4'hF);
    end
    f0 = frame_of(mdl);
    auto_trig = 1'b0;
`ifdef GPIO_AUTO_SHIFT_EN
    if (wr_cyc >= 0 && wd[15:0] != mdl[15:0]) auto_trig = 1'b1;
`endif
    nx = (extra > 0 || auto_trig) ? 2 : 1;
    k = 0; pen = 0; bad_idle = 0; unstable = 0; pclk = 1'b0; hold = 1'b0;
    while (k < 400) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      if (k == 0) begin
        chk({tag, " busy@load"}, busy, 1);
        chk({tag, " clk/sout@load"}, {led_clk, led_sout}, 2'b00);
      end
      if (led_clk && !pclk) bits.push_back(led_sout);
      if (!led_clk) hold = led_sout;
      else if (led_sout !== hold) unstable++;
      if (led_pen) begin
        pen++;
        if (led_clk || led_sout) bad_idle++;
      end
      if (done) dones.push_back(k);
      pclk = led_clk;
      if (k > 0 && !busy) break;
      if ((extra >= 1 && k == 5) || (extra >= 2 && k == 10)) start = 1'b1;
      if (k == wr_cyc) begin
        wr_en = 1'b1; wr_data = wd; wr_be = 4'hF;
        mdl = apply_wr(mdl, wd, 4'hF);
      end
      k++;
    end
    if (k >= 400) chk({tag, " timeout"}, 1, 0);
    fw = frame_of(mdl);
    chk({tag, " len"}, k, XFER * nx);
    chk({tag, " ndone"}, dones.size(), nx);
    if (dones.size() >= 1) chk({tag, " done cyc"}, dones[0], XFER - 1);
    if (dones.size() >= 2) chk({tag, " done gap"}, dones[1] - dones[0], XFER);
    chk({tag, " pen cycles"}, pen, CLK_DIV * nx);
    chk({tag, " pen quiet"}, bad_idle, 0);
    chk({tag, " sout stable"}, unstable, 0);
    chk({tag, " nbits"}, bits.size(), 16 * nx);
    if (bits.size() == 16 * nx)
      for (int f = 0; f < nx; f++) begin
        logic [15:0] w;
        for (int b = 0; b < 16; b++) w[b] = bits[f*16 + b];
        chk({tag, " frame"}, w, (f == 0) ? f0 : fw);
      end
    chk({tag, " gpio_q end"}, gpio_q, mdl);
  endtask

  initial begin
    int nd, nb;
    logic [31:0] v;
    #12;
    chk("rst gpio_q", gpio_q, 0);
    chk("rst outs", {busy, done, led_clk, led_sout, led_pen, led_clrn}, 6'b0);
    @(negedge clk); rst = 1'b0;
    chk("clrn before edge", led_clrn, 0);
    @(posedge clk); #1;
    chk("clrn after edge", led_clrn, 1);

    wr("w1", 32'h0000_0001, 4'hF);
    xfer("basic", 0, 1000, 0);

    mdl = '0;
    wr("clr", 32'h0, 4'hF);
    wr("be0010", 32'hFFFF_FFFF, 4'b0010);
    chk("be0010 val", gpio_q, 32'h0000_FF00);

    xfer("b2b", 2, 1000, 0);
    xfer("midwr", 0, 20, 32'h0000_AAAA);
    chk("midwr gpio", gpio_q, 32'h0000_AAAA);
    xfer("samecyc", 0, -1, 32'h1234_5A5A);

    for (int i = 0; i < 5; i++) begin
      wr("rnd wr", $urandom, 4'($urandom_range(0, 15)));
      xfer("rnd", 0, 1000, 0);
    end

    // reset in the middle of bit 7
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    mdl = '0;
    chk("midrst outs", {busy, done, led_clk, led_sout, led_pen, led_clrn}, 6'b0);
    chk("midrst gpio", gpio_q, 0);
    @(negedge clk); rst = 1'b0;
    chk("midrst clrn0", led_clrn, 0);
    @(posedge clk); #1;
    chk("midrst clrn1", led_clrn, 1);
    nd = 0; nb = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    chk("midrst no done", nd, 0);
    chk("midrst idle", nb, 0);

`ifdef GPIO_AUTO_SHIFT_EN
    v = {16'h0, ~mdl[15:0]};
    @(negedge clk); wr_en = 1'b1; wr_data = v; wr_be = 4'hF;
    @(negedge clk); wr_data = v;
    @(negedge clk); wr_en = 1'b0;
    mdl = v;
    nd = 0;
    repeat (200) begin @(negedge clk); if (done) nd++; end
    chk("auto one xfer", nd, 1);
    chk("auto gpio", gpio_q, mdl);
`else
    v = {16'h0, ~mdl[15:0]};
    @(negedge clk); wr_en = 1'b1; wr_data = v; wr_be = 4'hF;
    @(negedge clk); wr_en = 1'b0;
    mdl = v;
    nb = 0;
    repeat (20) begin @(negedge clk); if (busy) nb++; end
    chk("no auto xfer", nb, 0);
    chk("no auto gpio", gpio_q, mdl);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
